// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared types, channel ids and width helpers for sram_like_arbiter
package sram_like_arbiter_pkg;

   localparam int CH_DATA = 0;
   localparam int CH_INST = 1;

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HOLD = 1'b1
   } lock_state_e;

   function automatic int chid_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int strb_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// rtl/sram_like_arbiter_id_fifo.sv - in-order FIFO of issuing channel ids for outstanding transactions
module sram_like_arbiter_id_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] push_id,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a pop frees the slot the push lands in, so push+pop on full is legal
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - merges NUM_CH SRAM-like masters onto one slave port, routes in-order responses
// Optional round-robin grant with ARB_ROUND_ROBIN_EN; fixed lowest-index priority otherwise.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_wr,
   input  logic [NUM_CH*(DW/8)-1:0] ch_wstrb,
   input  logic [NUM_CH*AW-1:0]     ch_addr,
   input  logic [NUM_CH*DW-1:0]     ch_wdata,
   output logic [NUM_CH-1:0]        ch_addr_ok,
   output logic [NUM_CH-1:0]        ch_data_ok,
   output logic [DW-1:0]            ch_rdata,
   output logic                     m_req,
   output logic                     m_wr,
   output logic [(DW/8)-1:0]        m_wstrb,
   output logic [AW-1:0]            m_addr,
   output logic [DW-1:0]            m_wdata,
   input  logic                     m_addr_ok,
   input  logic                     m_data_ok,
   input  logic [DW-1:0]            m_rdata,
   output logic                     err_orphan
);

   localparam int CHID_W = chid_width(NUM_CH);
   localparam int SW     = strb_width(DW);

   logic [AW-1:0]     addr_arr  [NUM_CH];
   logic [DW-1:0]     wdata_arr [NUM_CH];
   logic [SW-1:0]     wstrb_arr [NUM_CH];
   lock_state_e       lock_state;
   logic [CHID_W-1:0] lock_ch;
   logic [CHID_W-1:0] pick;
   logic [CHID_W-1:0] grant;
   logic [CHID_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              pop;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         addr_arr[i]  = ch_addr[i*AW +: AW];
         wdata_arr[i] = ch_wdata[i*DW +: DW];
         wstrb_arr[i] = ch_wstrb[i*SW +: SW];
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [CHID_W-1:0] rr_ptr;
   logic [NUM_CH-1:0] req_rot;
   logic [CHID_W:0]   sum;

   // rotate so bit 0 is the channel at rr_ptr, then map the first hit back
   always_comb begin
      pick    = '0;
      sum     = '0;
      req_rot = NUM_CH'({ch_req, ch_req} >> rr_ptr);
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            sum = {1'b0, rr_ptr} + (CHID_W+1)'(i);
            if (sum >= (CHID_W+1)'(NUM_CH)) sum = sum - (CHID_W+1)'(NUM_CH);
            pick = sum[CHID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant == CHID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
   end
`else
   always_comb begin
      pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_req[i]) pick = CHID_W'(i);
      end
   end
`endif

   assign grant  = (lock_state == LOCK_HOLD) ? lock_ch : pick;
   // full blocks on the current count only; a same-cycle pop does not reopen the port
   assign m_req  = resetn & (|ch_req) & ~fifo_full;
   assign accept = m_req & m_addr_ok;
   assign pop    = m_data_ok & ~fifo_empty;

   assign m_wr     = m_req & ch_wr[grant];
   assign m_wstrb  = m_req ? wstrb_arr[grant] : '0;
   assign m_addr   = m_req ? addr_arr[grant]  : '0;
   assign m_wdata  = m_req ? wdata_arr[grant] : '0;
   assign ch_rdata = resetn ? m_rdata : '0;

   always_comb begin
      ch_addr_ok = '0;
      ch_data_ok = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_addr_ok[i] = accept & (grant == CHID_W'(i));
         ch_data_ok[i] = pop & (fifo_head == CHID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_state <= LOCK_IDLE;
         lock_ch    <= '0;
         err_orphan <= 1'b0;
      end else begin
         case (lock_state)
            LOCK_IDLE: begin
               if (m_req && !m_addr_ok) begin
                  lock_state <= LOCK_HOLD;
                  lock_ch    <= pick;
               end
            end
            LOCK_HOLD: begin
               if (accept) lock_state <= LOCK_IDLE;
            end
            default: lock_state <= LOCK_IDLE;
         endcase
         if (m_data_ok && fifo_empty) err_orphan <= 1'b1;
      end
   end

   sram_like_arbiter_id_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (CHID_W)
   ) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept),
      .push_id (grant),
      .pop     (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - scoreboard bench for sram_like_arbiter (fixed or ARB_ROUND_ROBIN_EN build)
module tb_sram_like_arbiter;
   import sram_like_arbiter_pkg::*;

   localparam int NUM_CH = 2, AW = 32, DW = 32, MAX_OUTST = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      int          ch;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   ntests = 0;
   int   nfail  = 0;

   logic                     clk = 1'b0;
   logic                     resetn;
   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH-1:0]        ch_wr;
   logic [NUM_CH*(DW/8)-1:0] ch_wstrb;
   logic [NUM_CH*AW-1:0]     ch_addr;
   logic [NUM_CH*DW-1:0]     ch_wdata;
   logic [NUM_CH-1:0]        ch_addr_ok;
   logic [NUM_CH-1:0]        ch_data_ok;
   logic [DW-1:0]            ch_rdata;
   logic                     m_req, m_wr;
   logic [(DW/8)-1:0]        m_wstrb;
   logic [AW-1:0]            m_addr;
   logic [DW-1:0]            m_wdata;
   logic                     m_addr_ok, m_data_ok;
   logic [DW-1:0]            m_rdata;
   logic                     err_orphan;

   always #5 clk = ~clk;

   sram_like_arbiter #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
      .ch_rdata(ch_rdata), .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .err_orphan(err_orphan));

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ch(input int c, input logic req, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
      ch_req[c]             = req;
      ch_wr[c]              = wr;
      ch_wstrb[c*4 +: 4]    = strb;
      ch_addr[c*32 +: 32]   = addr;
      ch_wdata[c*32 +: 32]  = wdata;
   endtask

   task automatic test_reset();
      resetn = 1'b0; ch_req = '1; ch_wr = '1; ch_wstrb = '1; ch_addr = '1; ch_wdata = '1;
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      ntests++; if (m_req !== 1'b0 || m_addr !== '0 || m_wr !== 1'b0) begin nfail++;
         $display("FAIL reset_mreq m_req=%b m_addr=%h m_wr=%b want 0", m_req, m_addr, m_wr); end
      ntests++; if (ch_addr_ok !== 2'b00 || ch_data_ok !== 2'b00) begin nfail++;
         $display("FAIL reset_chok addr_ok=%b data_ok=%b want 00", ch_addr_ok, ch_data_ok); end
      ntests++; if (err_orphan !== 1'b0 || ch_rdata !== '0) begin nfail++;
         $display("FAIL reset_err err_orphan=%b rdata=%h want 0", err_orphan, ch_rdata); end
      ch_req = '0; ch_wr = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
      resetn = 1'b1;
      next();
      #2;
      ntests++; if (err_orphan !== 1'b0 || m_req !== 1'b0) begin nfail++;
         $display("FAIL reset_idle err_orphan=%b m_req=%b want 0", err_orphan, m_req); end
   endtask

   task automatic test_single_read();
      drive_ch(CH_INST, 1'b1, 1'b0, 4'h0, 32'h1FC0_0000, 32'h0);
      m_addr_ok = 1'b1;
      #2;
      ntests++; if (m_req !== 1'b1 || m_addr !== 32'h1FC0_0000 || ch_addr_ok !== 2'b10) begin nfail++;
         $display("FAIL t1_accept m_req=%b m_addr=%h addr_ok=%b want 1 1fc00000 10", m_req, m_addr, ch_addr_ok); end
      exp_q.push_back('{CH_INST, 32'hDEAD_BEEF});
      next();
      drive_ch(CH_INST, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m_addr_ok = 1'b0;
      #2;
      ntests++; if (ch_data_ok !== 2'b00 || ch_addr_ok !== 2'b00) begin nfail++;
         $display("FAIL t1_idle data_ok=%b addr_ok=%b want 00", ch_data_ok, ch_addr_ok); end
      next();
      m_data_ok = 1'b1; e = exp_q.pop_front(); m_rdata = e.data;
      #2;
      ntests++; if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin nfail++;
         $display("FAIL t1_resp data_ok=%b rdata=%h want ch%0d %h", ch_data_ok, ch_rdata, e.ch, e.data); end
      next();
      m_data_ok = 1'b0;
   endtask

   task automatic test_arbitration();
      int g;
      drive_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
      drive_ch(1, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
      m_addr_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         g = RR ? (i % 2) : 0;
         m_data_ok = (i > 0);
         if (i > 0) begin e = exp_q.pop_front(); m_rdata = e.data; end
         #2;
         ntests++; if (ch_addr_ok !== 2'(1 << g) || m_addr !== ((g == 1) ? 32'h200 : 32'h100)) begin nfail++;
            $display("FAIL t2_grant%0d addr_ok=%b m_addr=%h want ch%0d", i, ch_addr_ok, m_addr, g); end
         if (i > 0) begin
            ntests++; if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin nfail++;
               $display("FAIL t2_resp%0d data_ok=%b rdata=%h want ch%0d %h", i, ch_data_ok, ch_rdata, e.ch, e.data); end
         end
         exp_q.push_back('{g, $urandom});
         next();
      end
      ch_req = '0; m_addr_ok = 1'b0;
      m_data_ok = 1'b1; e = exp_q.pop_front(); m_rdata = e.data;
      #2;
      ntests++; if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data || m_req !== 1'b0) begin nfail++;
         $display("FAIL t2_drain data_ok=%b rdata=%h m_req=%b want ch%0d %h", ch_data_ok, ch_rdata, m_req, e.ch, e.data); end
      next();
      m_data_ok = 1'b0;
   endtask

   task automatic test_lock();
      drive_ch(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
      m_addr_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0);
         m_addr_ok = (i == 3);
         #2;
         ntests++; if (m_addr !== 32'h300 || ch_addr_ok !== ((i == 3) ? 2'b10 : 2'b00)) begin nfail++;
            $display("FAIL t3_hold%0d m_addr=%h addr_ok=%b want 00000300", i, m_addr, ch_addr_ok); end
         next();
      end
      exp_q.push_back('{1, $urandom});
      ch_req[1] = 1'b0;
      #2;
      ntests++; if (m_addr !== 32'h400 || ch_addr_ok !== 2'b01) begin nfail++;
         $display("FAIL t3_next m_addr=%h addr_ok=%b want 00000400 01", m_addr, ch_addr_ok); end
      exp_q.push_back('{0, $urandom});
      next();
      ch_req = '0; m_addr_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_data_ok = 1'b1; e = exp_q.pop_front(); m_rdata = e.data;
         #2;
         ntests++; if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin nfail++;
            $display("FAIL t3_resp%0d data_ok=%b rdata=%h want ch%0d %h", k, ch_data_ok, ch_rdata, e.ch, e.data); end
         next();
      end
      m_data_ok = 1'b0;
   endtask

   task automatic test_full();
      int ids[4] = '{0, 1, 1, 0};
      int g;
      drive_ch(0, 1'b0, 1'b0, 4'h0, 32'h0000_0500, 32'h0);
      drive_ch(1, 1'b0, 1'b0, 4'h0, 32'h0000_0600, 32'h0);
      m_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ch_req = 2'(1 << ids[i]);
         #2;
         ntests++; if (ch_addr_ok !== 2'(1 << ids[i])) begin nfail++;
            $display("FAIL t4_fill%0d addr_ok=%b want ch%0d", i, ch_addr_ok, ids[i]); end
         exp_q.push_back('{ids[i], $urandom});
         next();
      end
      ch_req = 2'b11;
      #2;
      ntests++; if (m_req !== 1'b0 || ch_addr_ok !== 2'b00) begin nfail++;
         $display("FAIL t4_full m_req=%b addr_ok=%b want 0 00", m_req, ch_addr_ok); end
      next();
      m_data_ok = 1'b1; e = exp_q.pop_front(); m_rdata = e.data;
      #2;
      ntests++; if (m_req !== 1'b0 || ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin nfail++;
         $display("FAIL t4_popfull m_req=%b data_ok=%b rdata=%h want 0 ch%0d %h", m_req, ch_data_ok, ch_rdata, e.ch, e.data); end
      next();
      m_data_ok = 1'b0;
      g = RR ? 1 : 0;
      #2;
      ntests++; if (m_req !== 1'b1 || ch_addr_ok !== 2'(1 << g)) begin nfail++;
         $display("FAIL t4_reopen m_req=%b addr_ok=%b want 1 ch%0d", m_req, ch_addr_ok, g); end
      exp_q.push_back('{g, $urandom});
      next();
      ch_req = '0; m_addr_ok = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_data_ok = 1'b1;
         ntests++;
         if (exp_q.size() == 0) begin nfail++; $display("FAIL t4_sb_empty size=0 want >0"); end
         else begin
            e = exp_q.pop_front(); m_rdata = e.data;
            #2;
            if (ch_data_ok !== 2'(1 << e.ch) || ch_rdata !== e.data) begin nfail++;
               $display("FAIL t4_order%0d data_ok=%b rdata=%h want ch%0d %h", k, ch_data_ok, ch_rdata, e.ch, e.data); end
         end
         next();
      end
      m_data_ok = 1'b0;
   endtask

   task automatic test_write();
      drive_ch(0, 1'b1, 1'b1, 4'b0011, 32'h8000_0004, 32'h0000_1234);
      m_addr_ok = 1'b1;
      #2;
      ntests++; if (m_wr !== 1'b1 || m_wstrb !== 4'b0011 || m_addr !== 32'h8000_0004 || m_wdata !== 32'h1234
                    || ch_addr_ok !== 2'b01) begin nfail++;
         $display("FAIL t5_write wr=%b strb=%b addr=%h wdata=%h addr_ok=%b want 1 0011 80000004 1234 01",
                  m_wr, m_wstrb, m_addr, m_wdata, ch_addr_ok); end
      exp_q.push_back('{0, 32'h0});
      next();
      drive_ch(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m_addr_ok = 1'b0;
      next();
      m_data_ok = 1'b1; e = exp_q.pop_front(); m_rdata = e.data;
      #2;
      ntests++; if (ch_data_ok !== 2'(1 << e.ch)) begin nfail++;
         $display("FAIL t5_ack data_ok=%b want ch%0d", ch_data_ok, e.ch); end
      next();
      m_data_ok = 1'b0;
   endtask

   task automatic test_orphan();
      m_data_ok = 1'b1; m_rdata = 32'h5555_AAAA;
      #2;
      ntests++; if (ch_data_ok !== 2'b00 || err_orphan !== 1'b0) begin nfail++;
         $display("FAIL t6_orphan_now data_ok=%b err=%b want 00 0", ch_data_ok, err_orphan); end
      next();
      m_data_ok = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #2;
         ntests++; if (err_orphan !== 1'b1) begin nfail++;
            $display("FAIL t6_sticky%0d err=%b want 1", k, err_orphan); end
         next();
      end
      m_addr_ok = 1'b1;
      ch_req = 2'b01; next();
      ch_req = 2'b10; next();
      ch_req = 2'b11; m_addr_ok = 1'b0;
      resetn = 1'b0;
      #2;
      ntests++; if (err_orphan !== 1'b0 || m_req !== 1'b0) begin nfail++;
         $display("FAIL t6_reset err=%b m_req=%b want 0 0", err_orphan, m_req); end
      next();
      resetn = 1'b1; ch_req = '0; m_data_ok = 1'b1;
      #2;
      ntests++; if (ch_data_ok !== 2'b00) begin nfail++;
         $display("FAIL t6_late data_ok=%b want 00", ch_data_ok); end
      next();
      m_data_ok = 1'b0;
      #2;
      ntests++; if (err_orphan !== 1'b1) begin nfail++;
         $display("FAIL t6_late_err err=%b want 1", err_orphan); end
      next();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_arbitration();
      test_lock();
      test_full();
      test_write();
      test_orphan();
      ntests++; if (exp_q.size() != 0) begin nfail++;
         $display("FAIL sb_leftover size=%0d want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
